// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between NREQ
// writeback requesters; the winner is registered onto we3/A3/WD3 one cycle after acceptance.
module regfile_wr_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int CW   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               we3,
    output logic [AW-1:0]      A3,
    output logic [DW-1:0]      WD3,
    output logic [1:0]         grant_id,
    output logic               zero_drop,
    output logic [CW-1:0]      wr_count
);

    logic [1:0]      r_rr_ptr;
    logic            r_we3;
    logic [AW-1:0]   r_a3;
    logic [DW-1:0]   r_wd3;
    logic [1:0]      r_grant_id;
    logic            r_zero_drop;
    logic [CW-1:0]   r_wr_count;

    logic [NREQ-1:0] w_ready;
    logic [1:0]      w_win;
    logic            w_found;
    logic [2:0]      w_idx;
    logic            w_xfer;
    logic [1:0]      w_ptr_next;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;
    logic [AW-1:0]   w_addr_arr [NREQ];
    logic [DW-1:0]   w_data_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_addr_arr[gi] = req_addr[gi*AW +: AW];
            assign w_data_arr[gi] = req_data[gi*DW +: DW];
        end
    endgenerate

    // Scan from the pointer upward (mod NREQ); the first valid requester wins.
    always_comb begin
        w_ready = '0;
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        if (!stall) begin
            for (int k = 0; k < NREQ; k++) begin
                w_idx = {1'b0, r_rr_ptr} + 3'(k);
                if (w_idx >= 3'(NREQ))
                    w_idx = w_idx - 3'(NREQ);
                for (int j = 0; j < NREQ; j++) begin
                    if (!w_found && (w_idx == 3'(j)) && req_valid[j]) begin
                        w_ready[j] = 1'b1;
                        w_win      = 2'(j);
                        w_found    = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_ready[j]) begin
                w_addr = w_addr_arr[j];
                w_data = w_data_arr[j];
            end
        end
    end

    assign w_xfer     = |w_ready;
    assign w_ptr_next = (w_win == 2'(NREQ - 1)) ? 2'd0 : w_win + 2'd1;

    // Writes to register 0 are accepted (pointer advances) but never reach the write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr    <= '0;
            r_we3       <= 1'b0;
            r_a3        <= '0;
            r_wd3       <= '0;
            r_grant_id  <= '0;
            r_zero_drop <= 1'b0;
            r_wr_count  <= '0;
        end else if (w_xfer) begin
            r_a3       <= w_addr;
            r_wd3      <= w_data;
            r_grant_id <= w_win;
            r_rr_ptr   <= w_ptr_next;
            if (w_addr != '0) begin
                r_we3       <= 1'b1;
                r_zero_drop <= 1'b0;
                if (r_wr_count != '1)
                    r_wr_count <= r_wr_count + 1'b1;
            end else begin
                r_we3       <= 1'b0;
                r_zero_drop <= 1'b1;
            end
        end else begin
            r_we3       <= 1'b0;
            r_zero_drop <= 1'b0;
        end
    end

    assign req_ready = w_ready;
    assign we3       = r_we3;
    assign A3        = r_a3;
    assign WD3       = r_wd3;
    assign grant_id  = r_grant_id;
    assign zero_drop = r_zero_drop;
    assign wr_count  = r_wr_count;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Testbench for regfile_wr_arbiter: directed scenarios plus randomized traffic checked
// against a queue-free behavioural model of round-robin writeback arbitration.
module tb_regfile_wr_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int CW   = 16;
    localparam int SCW  = 3;
    localparam int SMAX = (1 << SCW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic               stall;
    logic [NREQ-1:0]    req_valid;
    logic [AW-1:0]      a_q [NREQ];
    logic [DW-1:0]      d_q [NREQ];
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW] = a_q[i];
            req_data[i*DW +: DW] = d_q[i];
        end
    end

    logic [NREQ-1:0] req_ready;
    logic            we3, zero_drop;
    logic [AW-1:0]   A3;
    logic [DW-1:0]   WD3;
    logic [1:0]      grant_id;
    logic [CW-1:0]   wr_count;

    logic [NREQ-1:0] s_req_ready;
    logic            s_we3, s_zero_drop;
    logic [AW-1:0]   s_A3;
    logic [DW-1:0]   s_WD3;
    logic [1:0]      s_grant_id;
    logic [SCW-1:0]  s_wr_count;

    regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .req_valid(req_valid),
        .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .we3(we3), .A3(A3), .WD3(WD3), .grant_id(grant_id),
        .zero_drop(zero_drop), .wr_count(wr_count)
    );

    // Narrow-counter copy so saturation is reachable in a few writes.
    regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(SCW)) dut_sat (
        .clk(clk), .reset(reset), .stall(stall), .req_valid(req_valid),
        .req_addr(req_addr), .req_data(req_data), .req_ready(s_req_ready),
        .we3(s_we3), .A3(s_A3), .WD3(s_WD3), .grant_id(s_grant_id),
        .zero_drop(s_zero_drop), .wr_count(s_wr_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int            m_ptr;
    logic          m_we3, m_zd;
    logic [AW-1:0] m_A3;
    logic [DW-1:0] m_WD3;
    logic [1:0]    m_gid;
    int            m_cnt, m_scnt;
    int            last_win;

    function automatic int model_winner();
        if (stall) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        logic [NREQ-1:0] r;
        int w;
        r = '0;
        w = model_winner();
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    function automatic logic [59:0] dut_vec();
        return {we3, A3, WD3, grant_id, zero_drop, wr_count, s_wr_count};
    endfunction

    function automatic logic [59:0] exp_vec();
        return {m_we3, m_A3, m_WD3, m_gid, m_zd, CW'(m_cnt), SCW'(m_scnt)};
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_we3 = 0; m_zd = 0; m_A3 = '0; m_WD3 = '0; m_gid = '0;
        m_cnt = 0; m_scnt = 0; last_win = -1;
    endtask

    task automatic clear_inputs();
        stall = 0; req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin a_q[i] = '0; d_q[i] = '0; end
    endtask

    // Advance one clock edge and apply the arbitration rules to the model.
    task automatic step();
        int w;
        w = model_winner();
        @(posedge clk);
        if (w >= 0) begin
            m_A3 = a_q[w]; m_WD3 = d_q[w]; m_gid = 2'(w);
            m_ptr = (w + 1) % NREQ;
            if (a_q[w] != '0) begin
                m_we3 = 1; m_zd = 0;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
                if (m_scnt < SMAX) m_scnt++;
            end else begin
                m_we3 = 0; m_zd = 1;
            end
        end else begin
            m_we3 = 0; m_zd = 0;
        end
        last_win = w;
        #1;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 0;
        #2;
        model_reset();
        reset = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (dut_vec() !== 60'd0) begin
            n_bad++; $display("FAIL reset_state got %h exp %h", dut_vec(), 60'd0);
        end
        reset = 1;
        step();
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL reset_idle got %h exp %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_single();
        req_valid = 2'b01; a_q[0] = 5'd5; d_q[0] = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_bad++; $display("FAIL single_ready got %b exp %b", req_ready, 2'b01);
        end
        step();
        req_valid = '0;
        n_cmp++;
        if ({we3, A3, WD3, wr_count} !== {1'b1, 5'd5, 32'hDEADBEEF, 16'd1}) begin
            n_bad++; $display("FAIL single_out got we3=%b A3=%0d WD3=%h cnt=%0d exp 1 5 DEADBEEF 1",
                              we3, A3, WD3, wr_count);
        end
        step();
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL single_idle got %h exp %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] exp_a;
        apply_reset();
        req_valid = 2'b11; a_q[0] = 5'd3; a_q[1] = 5'd7;
        d_q[0] = 32'h0000_AAAA; d_q[1] = 32'h0000_BBBB;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if (req_ready !== exp_ready()) begin
                n_bad++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, exp_ready());
            end
            step();
            exp_a = (k % 2 == 0) ? 5'd3 : 5'd7;
            n_cmp++;
            if ({we3, grant_id, A3} !== {1'b1, 2'(k % 2), exp_a}) begin
                n_bad++; $display("FAIL rr_grant[%0d] got we3=%b gid=%0d A3=%0d exp 1 %0d %0d",
                                  k, we3, grant_id, A3, k % 2, exp_a);
            end
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_zero_reg();
        int cnt_before;
        cnt_before = int'(wr_count);
        req_valid = 2'b10; a_q[1] = 5'd0; d_q[1] = 32'h1234;
        #1;
        n_cmp++;
        if (req_ready !== 2'b10) begin
            n_bad++; $display("FAIL zero_ready got %b exp %b", req_ready, 2'b10);
        end
        step();
        req_valid = '0;
        n_cmp++;
        if ({we3, zero_drop, wr_count} !== {1'b0, 1'b1, 16'(cnt_before)}) begin
            n_bad++; $display("FAIL zero_drop got we3=%b zd=%b cnt=%0d exp 0 1 %0d",
                              we3, zero_drop, wr_count, cnt_before);
        end
        step();
        n_cmp++;
        if (zero_drop !== 1'b0) begin
            n_bad++; $display("FAIL zero_pulse got %b exp 0", zero_drop);
        end
    endtask

    task automatic test_stall();
        req_valid = 2'b11; a_q[0] = 5'd9; a_q[1] = 5'd10;
        d_q[0] = 32'hC0DE_0000; d_q[1] = 32'hC0DE_0001;
        step();
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (req_ready !== 2'b00) begin
                n_bad++; $display("FAIL stall_ready[%0d] got %b exp 00", k, req_ready);
            end
            step();
            n_cmp++;
            if (dut_vec() !== exp_vec() || we3 !== 1'b0) begin
                n_bad++; $display("FAIL stall_out[%0d] got %h exp %h", k, dut_vec(), exp_vec());
            end
        end
        stall = 0;
        #1;
        n_cmp++;
        if (req_ready !== exp_ready()) begin
            n_bad++; $display("FAIL stall_resume got %b exp %b", req_ready, exp_ready());
        end
        step();
        req_valid = '0;
        step();
    endtask

    task automatic test_async_reset();
        req_valid = 2'b01; a_q[0] = 5'd12; d_q[0] = 32'h5555_AAAA;
        step();
        n_cmp++;
        if (we3 !== 1'b1) begin
            n_bad++; $display("FAIL areset_pre got we3=%b exp 1", we3);
        end
        #2 reset = 0;
        #1;
        n_cmp++;
        if ({we3, wr_count} !== {1'b0, 16'd0}) begin
            n_bad++; $display("FAIL areset_now got we3=%b cnt=%0d exp 0 0", we3, wr_count);
        end
        model_reset();
        req_valid = 2'b11; a_q[1] = 5'd13;
        #4 reset = 1;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_bad++; $display("FAIL areset_first got %b exp 01", req_ready);
        end
        step();
        req_valid[last_win] = 1'b0;
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL areset_out got %h exp %h", dut_vec(), exp_vec());
        end
        step();
        req_valid = '0;
        step();
    endtask

    task automatic test_saturation();
        apply_reset();
        a_q[0] = 5'd1; a_q[1] = 5'd2; d_q[0] = 32'h1; d_q[1] = 32'h2;
        req_valid = 2'b11;
        repeat (SMAX - 1) step();
        n_cmp++;
        if (s_wr_count !== SCW'(SMAX - 1)) begin
            n_bad++; $display("FAIL sat_pre got %0d exp %0d", s_wr_count, SMAX - 1);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (s_wr_count !== SCW'(SMAX) || wr_count !== CW'(SMAX + k)) begin
                n_bad++; $display("FAIL sat[%0d] got %0d/%0d exp %0d/%0d",
                                  k, s_wr_count, wr_count, SMAX, SMAX + k);
            end
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    req_valid[i] = 1'b1;
                    a_q[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                    d_q[i] = $urandom;
                end
            end
            stall = ($urandom_range(0, 4) == 0);
            #1;
            n_cmp++;
            if (req_ready !== exp_ready()) begin
                n_bad++; $display("FAIL rand_ready[%0d] got %b exp %b", c, req_ready, exp_ready());
            end
            step();
            if (last_win >= 0) req_valid[last_win] = 1'b0;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL rand_out[%0d] got %h exp %h", c, dut_vec(), exp_vec());
            end
        end
        clear_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_reg();
        test_stall();
        test_async_reset();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
